// File: rtl/spi_slave_rd.sv
// SPI mode-0 slave front-end: streams DMA buffer bytes to the host, reports
// block-ready status and accepts a 17-bit transfer depth.
module spi_slave_rd #(
    parameter logic [16:0] DEPTH_RST = 17'h00800
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        spi_cs_n,
    input  logic        spi_sclk,
    input  logic        spi_mosi,
    output logic        spi_miso,
    output logic        spi_miso_oe,
    output logic        spi_rd_ena,
    input  logic        dma_en_out,
    input  logic [7:0]  dma_dout,
    input  logic        dma_int,
    output logic [16:0] dma_depth,
    output logic        spi_int
);

    typedef enum logic [2:0] {IDLE, CMD, RD, STAT, WDEP, IGN} state_t;

    state_t      state;
    logic [2:0]  cs_sr;
    logic [2:0]  sclk_sr;
    logic [2:0]  mosi_sr;
    logic [2:0]  bit_cnt;
    logic [7:0]  rx_sr;
    logic        rx_done;
    logic [7:0]  tx_sr;
    logic [7:0]  hold;
    logic        load_pend;
    logic        ready;
    logic        ovf;
    logic [1:0]  wcnt;
    logic        b0_lsb;
    logic [7:0]  b1;

    logic cs_act, cs_rise, cs_fall, sclk_rise, sclk_fall;
    logic dec_rd, dec_stat;
    logic [7:0] rx_next;

    // [1] is the synchronised sample, [2] its one-cycle history
    assign cs_act    = ~cs_sr[1];
    assign cs_rise   = ~cs_sr[1] &  cs_sr[2];
    assign cs_fall   =  cs_sr[1] & ~cs_sr[2];
    assign sclk_rise =  sclk_sr[1] & ~sclk_sr[2];
    assign sclk_fall = ~sclk_sr[1] &  sclk_sr[2];
    assign rx_next   = {rx_sr[6:0], mosi_sr[2]};

    assign dec_rd   = rx_done && (state == CMD) && (rx_sr == 8'h0B);
    assign dec_stat = rx_done && (state == CMD) && (rx_sr == 8'h05);

    assign spi_miso_oe = cs_act;
    assign spi_miso    = cs_act & tx_sr[7];
    assign spi_int     = ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            cs_sr      <= '1;
            sclk_sr    <= '0;
            mosi_sr    <= '0;
            bit_cnt    <= '0;
            rx_sr      <= '0;
            rx_done    <= 1'b0;
            tx_sr      <= '0;
            hold       <= '0;
            load_pend  <= 1'b0;
            ready      <= 1'b0;
            ovf        <= 1'b0;
            wcnt       <= '0;
            b0_lsb     <= 1'b0;
            b1         <= '0;
            spi_rd_ena <= 1'b0;
            dma_depth  <= DEPTH_RST;
        end else begin
            cs_sr      <= {cs_sr[1:0], spi_cs_n};
            sclk_sr    <= {sclk_sr[1:0], spi_sclk};
            mosi_sr    <= {mosi_sr[1:0], spi_mosi};
            rx_done    <= 1'b0;
            spi_rd_ena <= 1'b0;

            if (dma_int)
                ready <= 1'b1;
            else if (dec_rd)
                ready <= 1'b0;
            if (dma_int && ready)
                ovf <= 1'b1;
            else if (dec_stat)
                ovf <= 1'b0;

            if (!cs_act) begin
                bit_cnt   <= '0;
                load_pend <= 1'b0;
                tx_sr     <= '0;
            end else if (sclk_rise) begin
                rx_sr   <= rx_next;
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    rx_done   <= 1'b1;
                    load_pend <= 1'b1;
                end
            end else if (sclk_fall) begin
                if (load_pend) begin
                    // Each byte moved into the shifter prefetches its successor
                    tx_sr     <= hold;
                    load_pend <= 1'b0;
                    if (state == RD)
                        spi_rd_ena <= 1'b1;
                    if (state == STAT)
                        hold <= {ready, ovf, 6'b0};
                end else begin
                    tx_sr <= {tx_sr[6:0], 1'b0};
                end
            end

            if (cs_fall) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: if (cs_rise) state <= CMD;
                    CMD: begin
                        if (rx_done) begin
                            hold <= '0;
                            case (rx_sr)
                                8'h0B: begin
                                    state      <= RD;
                                    spi_rd_ena <= 1'b1;
                                end
                                8'h05: begin
                                    state <= STAT;
                                    hold  <= {ready, ovf, 6'b0};
                                end
                                8'h02: begin
                                    state <= WDEP;
                                    wcnt  <= '0;
                                end
                                default: state <= IGN;
                            endcase
                        end
                    end
                    RD: if (dma_en_out) hold <= dma_dout;
                    WDEP: begin
                        if (rx_done) begin
                            case (wcnt)
                                2'd0:    b0_lsb    <= rx_sr[0];
                                2'd1:    b1        <= rx_sr;
                                2'd2:    dma_depth <= {b0_lsb, b1, rx_sr};
                                default: ;
                            endcase
                            if (wcnt != 2'd3)
                                wcnt <= wcnt + 2'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_slave_rd.sv
// Directed bench for spi_slave_rd: host SPI driver, DMA read model and a
// MISO byte scoreboard fed by the stimulus.
`timescale 1ns/1ps
module tb_spi_slave_rd;

    localparam int HALF = 100;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        spi_cs_n = 1'b1;
    logic        spi_sclk = 1'b0;
    logic        spi_mosi = 1'b0;
    logic        spi_miso;
    logic        spi_miso_oe;
    logic        spi_rd_ena;
    logic        dma_en_out = 1'b0;
    logic [7:0]  dma_dout = '0;
    logic        dma_int = 1'b0;
    logic [16:0] dma_depth;
    logic        spi_int;

    int checks = 0;
    int failures = 0;
    logic [7:0] exp_q[$];

    int rd_pulses = 0;
    int dma_n = 0;
    logic [2:0] en_pipe = '0;

    logic [7:0] mon_sr = '0;
    int mon_bits = 0;

    spi_slave_rd #(.DEPTH_RST(17'h00800)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .spi_cs_n(spi_cs_n),
        .spi_sclk(spi_sclk),
        .spi_mosi(spi_mosi),
        .spi_miso(spi_miso),
        .spi_miso_oe(spi_miso_oe),
        .spi_rd_ena(spi_rd_ena),
        .dma_en_out(dma_en_out),
        .dma_dout(dma_dout),
        .dma_int(dma_int),
        .dma_depth(dma_depth),
        .spi_int(spi_int)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // DMA stage: returns 0x11, 0x22, ... one byte per strobe, 3 clk later
    always @(negedge clk) begin
        if (spi_rd_ena) rd_pulses++;
        en_pipe = {en_pipe[1:0], spi_rd_ena};
        dma_en_out = en_pipe[2];
        if (en_pipe[2]) begin
            dma_dout = 8'((dma_n + 1) * 17);
            dma_n++;
        end
    end

    // Host-side MISO monitor: pops one expected byte per complete byte
    always @(posedge spi_sclk or posedge spi_cs_n) begin
        if (spi_cs_n) begin
            mon_bits = 0;
        end else begin
            mon_sr = {mon_sr[6:0], spi_miso};
            mon_bits++;
            if (mon_bits == 8) begin
                mon_bits = 0;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL miso_unexpected got=%h exp=none", mon_sr);
                end else begin
                    check("miso_byte", {24'h0, mon_sr}, {24'h0, exp_q.pop_front()});
                end
            end
        end
    end

    task automatic spi_bit(input logic b);
        spi_sclk = 1'b0;
        spi_mosi = b;
        #HALF;
        spi_sclk = 1'b1;
        #HALF;
    endtask

    task automatic spi_byte(input logic [7:0] tx, input logic [7:0] exp_miso);
        exp_q.push_back(exp_miso);
        for (int i = 7; i >= 0; i--) spi_bit(tx[i]);
    endtask

    task automatic cs_low();
        spi_cs_n = 1'b0;
        #HALF;
    endtask

    task automatic cs_high();
        spi_cs_n = 1'b1;
        #HALF;
        spi_sclk = 1'b0;
        #(HALF * 2);
    endtask

    task automatic pulse_dma_int();
        @(posedge clk); #1 dma_int = 1'b1;
        @(posedge clk); #1 dma_int = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    int p0;

    initial begin
        reset_n = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("rst_miso", {31'h0, spi_miso}, 0);
        check("rst_oe", {31'h0, spi_miso_oe}, 0);
        check("rst_rd_ena", {31'h0, spi_rd_ena}, 0);
        check("rst_int", {31'h0, spi_int}, 0);
        check("rst_depth", {15'h0, dma_depth}, 32'h00800);
        reset_n = 1'b1;
        repeat (5) @(posedge clk);

        // Status reads
        pulse_dma_int();
        check("int_after_dma_int", {31'h0, spi_int}, 1);
        cs_low(); spi_byte(8'h05, 8'h00); spi_byte(8'h00, 8'h80); cs_high();
        pulse_dma_int();
        pulse_dma_int();
        cs_low(); spi_byte(8'h05, 8'h00); spi_byte(8'h00, 8'hC0); spi_byte(8'h00, 8'h80); cs_high();
        cs_low(); spi_byte(8'h05, 8'h00); spi_byte(8'h00, 8'h80); cs_high();
        check("int_held", {31'h0, spi_int}, 1);
        check("stat_no_strobes", rd_pulses, 0);

        // Read stream
        p0 = rd_pulses;
        cs_low();
        spi_byte(8'h0B, 8'h00);
        spi_byte(8'h00, 8'h11);
        spi_byte(8'h00, 8'h22);
        spi_byte(8'h00, 8'h33);
        spi_byte(8'h00, 8'h44);
        cs_high();
        repeat (10) @(posedge clk);
        #1;
        check("stream_strobes", rd_pulses - p0, 5);
        check("int_cleared_by_rd", {31'h0, spi_int}, 0);

        // Depth write, trailing byte ignored
        cs_low();
        spi_byte(8'h02, 8'h00); spi_byte(8'h01, 8'h00); spi_byte(8'hA5, 8'h00);
        spi_byte(8'h5A, 8'h00); spi_byte(8'hFF, 8'h00);
        cs_high();
        check("depth_write", {15'h0, dma_depth}, 32'h1A55A);
        cs_low(); spi_byte(8'h02, 8'h00); spi_byte(8'h00, 8'h00); cs_high();
        check("depth_partial", {15'h0, dma_depth}, 32'h1A55A);

        // Abort mid-byte in RD; the prefetched 0x88 is lost
        p0 = rd_pulses;
        cs_low();
        spi_byte(8'h0B, 8'h00);
        spi_byte(8'h00, 8'h66);
        spi_bit(1'b0); spi_bit(1'b0); spi_bit(1'b0);
        cs_high();
        repeat (20) @(posedge clk);
        #1;
        check("abort_strobes", rd_pulses - p0, 3);
        repeat (40) @(posedge clk);
        #1;
        check("abort_idle_strobes", rd_pulses - p0, 3);
        p0 = rd_pulses;
        cs_low(); spi_byte(8'h0B, 8'h00); spi_byte(8'h00, 8'h99); cs_high();
        check("resume_strobes", rd_pulses - p0, 2);

        // Unknown command
        p0 = rd_pulses;
        cs_low(); spi_byte(8'h7E, 8'h00); spi_byte(8'h12, 8'h00); spi_byte(8'h34, 8'h00); cs_high();
        check("ign_strobes", rd_pulses - p0, 0);
        check("ign_depth", {15'h0, dma_depth}, 32'h1A55A);

        // Reset mid-RD
        cs_low();
        spi_byte(8'h0B, 8'h00);
        pulse_dma_int();
        check("int_before_reset", {31'h0, spi_int}, 1);
        spi_bit(1'b0); spi_bit(1'b1); spi_bit(1'b0); spi_bit(1'b1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_miso", {31'h0, spi_miso}, 0);
        check("mid_rst_oe", {31'h0, spi_miso_oe}, 0);
        check("mid_rst_rd_ena", {31'h0, spi_rd_ena}, 0);
        check("mid_rst_int", {31'h0, spi_int}, 0);
        check("mid_rst_depth", {15'h0, dma_depth}, 32'h00800);
        spi_cs_n = 1'b1;
        spi_sclk = 1'b0;
        #50;
        reset_n = 1'b1;
        repeat (10) @(posedge clk);

        check("scoreboard_drain", 32'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
